circuito1_bist_ctrl: RTL and testbench

Built-in self-test controller for the three-input combinational block Circuito1. On a start request it drives the block's inputs `a`, `b`, `c` through all eight combinations in ascending binary order, with `a` as MSB. It samples `out_1` after a programmable settle time and compares the captured truth table against an expected one. It sits between the test/control logic and Circuito1, and replaces the bench-only exhaustive sweep with an on-chip sequencer.

---
 rtl/circuito1_bist_ctrl.sv | 142 ++++++++++++++
 tb/tb_circuito1_bist_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuito1_bist_ctrl.sv
// circuito1_bist_ctrl: built-in self-test sequencer for the three-input block Circuito1.
// It steps {a,b,c} through 000..111 and holds each vector for SETTLE_CYCLES+1 cycles.
// out_1 is sampled on the last cycle of each vector, and the captured truth table is
// compared against EXPECTED.
// Optional build macro: CIRCUITO1_BIST_STOP_ON_FAIL_EN makes the first mismatch end the sweep.
module circuito1_bist_ctrl #(
    parameter logic [7:0]  EXPECTED      = 8'hE8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       out_1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_vec,
    output logic [7:0] captured
);

    localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;          // current vector index, driven straight onto {a,b,c}
    logic [7:0] cnt_q, cnt_d;          // settle counter within the current vector
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic [7:0] captured_q, captured_d;
    logic       mism_q, mism_d;        // sticky: a mismatch has already been recorded

    logic       sample_mism;
    logic       last_sample;

    // Next-state and result update for the sweep sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        captured_d  = captured_q;
        mism_d      = mism_q;
        sample_mism = (out_1 != EXPECTED[idx_q]);
        last_sample = (idx_q == 3'd7);
`ifdef CIRCUITO1_BIST_STOP_ON_FAIL_EN
        // The first mismatch also terminates the sweep on its sample edge.
        last_sample = last_sample || (sample_mism && !mism_q);
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 3'd0;
                    cnt_d      = 8'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    fail_vec_d = 3'd0;
                    captured_d = 8'h00;
                    mism_d     = 1'b0;
                end
            end
            StRun: begin
                if (cnt_q != SettleMax) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // Sample edge: capture, record the first mismatch, advance or finish.
                    captured_d[idx_q] = out_1;
                    cnt_d             = 8'd0;
                    if (sample_mism && !mism_q) begin
                        fail_vec_d = idx_q;
                        mism_d     = 1'b1;
                    end
                    if (last_sample) begin
                        // Vector stays on {a,b,c} so DONE shows the last applied one.
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !(mism_q || sample_mism);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= 3'd0;
            captured_q <= 8'h00;
            mism_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            captured_q <= captured_d;
            mism_q     <= mism_d;
        end
    end

    // Registered outputs
    always_comb begin
        a        = idx_q[2];
        b        = idx_q[1];
        c        = idx_q[0];
        busy     = busy_q;
        done     = done_q;
        pass     = pass_q;
        fail_vec = fail_vec_q;
        captured = captured_q;
    end

endmodule

// File: tb/tb_circuito1_bist_ctrl.sv
// Directed bench for circuito1_bist_ctrl: a default instance plus a SETTLE_CYCLES=0 instance.
// Each one drives a behavioural Circuito1 model that acts as a majority gate or as stuck-at-0.
module tb_circuito1_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start0;
    logic       maj_mode;

    logic       a, b, c, out_1, busy, done, pass;
    logic [2:0] fail_vec;
    logic [7:0] captured;

    logic       a0, b0, c0, out0, busy0, done0, pass0;
    logic [2:0] fail_vec0;
    logic [7:0] captured0;

    int n_vec;
    int n_fail;

    // Circuito1 model: majority of the inputs, or output stuck at 0
    assign out_1 = maj_mode & ((a & b) | (a & c) | (b & c));
    assign out0  = maj_mode & ((a0 & b0) | (a0 & c0) | (b0 & c0));

    circuito1_bist_ctrl #(
        .EXPECTED     (8'hE8),
        .SETTLE_CYCLES(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .out_1   (out_1),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .fail_vec(fail_vec),
        .captured(captured)
    );

    circuito1_bist_ctrl #(
        .EXPECTED     (8'hE8),
        .SETTLE_CYCLES(0)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start0),
        .a       (a0),
        .b       (b0),
        .c       (c0),
        .out_1   (out0),
        .busy    (busy0),
        .done    (done0),
        .pass    (pass0),
        .fail_vec(fail_vec0),
        .captured(captured0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for exactly one accepting edge; returns 1 time unit after that edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({a, b, c, busy, done, pass, fail_vec, captured} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected all zero",
                     {a, b, c, busy, done, pass, fail_vec, captured});
        end
        n_vec++;
        if ({a0, b0, c0, busy0, done0, pass0, fail_vec0, captured0} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state0: got %b expected all zero",
                     {a0, b0, c0, busy0, done0, pass0, fail_vec0, captured0});
        end
    endtask

    task automatic test_majority();
        logic [2:0] exp_v;
        maj_mode = 1'b1;
        pulse_start();
        n_vec++;
        if ({a, b, c, busy, done} !== 5'b000_10) begin
            n_fail++;
            $display("FAIL maj_accept: got abc/busy/done=%b expected 00010", {a, b, c, busy, done});
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k < 16) ? 3'(k / 2) : 3'd7;
            n_vec++;
            if ({a, b, c} !== exp_v || done !== (k == 16) || busy !== (k != 16)) begin
                n_fail++;
                $display("FAIL maj_step edge %0d: got abc=%b done=%b busy=%b expected abc=%b done=%b",
                         k, {a, b, c}, done, busy, exp_v, (k == 16));
            end
        end
        n_vec++;
        if (captured !== 8'hE8 || pass !== 1'b1 || fail_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL maj_result: got captured=%h pass=%b fail_vec=%0d expected e8 1 0",
                     captured, pass, fail_vec);
        end
    endtask

    task automatic test_stuck();
        int edges;
        int exp_edges;
        logic [2:0] exp_v;
`ifdef CIRCUITO1_BIST_STOP_ON_FAIL_EN
        exp_edges = 8;
        exp_v     = 3'b011;
`else
        exp_edges = 16;
        exp_v     = 3'b111;
`endif
        maj_mode = 1'b0;
        edges    = 0;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
        n_vec++;
        if (edges !== exp_edges) begin
            n_fail++;
            $display("FAIL stuck_latency: got done at edge %0d expected %0d (0 = timeout)",
                     edges, exp_edges);
        end
        n_vec++;
        if (captured !== 8'h00 || pass !== 1'b0 || fail_vec !== 3'd3 || {a, b, c} !== exp_v) begin
            n_fail++;
            $display("FAIL stuck_result: got captured=%h pass=%b fail_vec=%0d abc=%b expected 00 0 3 %b",
                     captured, pass, fail_vec, {a, b, c}, exp_v);
        end
    endtask

    task automatic test_settle0();
        int edges;
        maj_mode = 1'b1;
        edges    = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) begin
                n_vec++;
                if ({a0, b0, c0} !== 3'(k)) begin
                    n_fail++;
                    $display("FAIL s0_step edge %0d: got abc=%b expected %b", k, {a0, b0, c0}, 3'(k));
                end
            end
            if (done0) begin
                edges = k;
                break;
            end
        end
        n_vec++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL s0_latency: got done at edge %0d expected 8 (0 = timeout)", edges);
        end
        n_vec++;
        if (captured0 !== 8'hE8 || pass0 !== 1'b1 || fail_vec0 !== 3'd0) begin
            n_fail++;
            $display("FAIL s0_result: got captured=%h pass=%b fail_vec=%0d expected e8 1 0",
                     captured0, pass0, fail_vec0);
        end
    endtask

    task automatic test_ignore_start();
        maj_mode = 1'b1;
        pulse_start();
        for (int k = 1; k <= 17; k++) begin
            start = (k == 3 || k == 9 || k == 16 || k == 17);
            @(posedge clk);
            #1;
            start = 1'b0;
            n_vec++;
            if (k < 16 && ({a, b, c} !== 3'(k / 2) || done !== 1'b0 || busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL ign_run edge %0d: got abc=%b done=%b busy=%b expected abc=%b done=0 busy=1",
                         k, {a, b, c}, done, busy, 3'(k / 2));
            end else if (k == 16 && (done !== 1'b1 || busy !== 1'b0 || captured !== 8'hE8)) begin
                n_fail++;
                $display("FAIL ign_done: got done=%b busy=%b captured=%h expected 1 0 e8",
                         done, busy, captured);
            end else if (k == 17 && (done !== 1'b0 || busy !== 1'b1 || captured !== 8'h00
                                     || {a, b, c} !== 3'b000)) begin
                n_fail++;
                $display("FAIL ign_restart: got done=%b busy=%b captured=%h abc=%b expected 0 1 00 000",
                         done, busy, captured, {a, b, c});
            end
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        apply_reset();
        maj_mode = 1'b1;
        pulse_start();
        for (int k = 1; k <= 7; k++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({a, b, c, busy, done, pass, fail_vec, captured} !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected all zero before next edge",
                     {a, b, c, busy, done, pass, fail_vec, captured});
        end
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
        n_vec++;
        if (edges !== 16 || pass !== 1'b1 || captured !== 8'hE8 || fail_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_sweep: got edge=%0d pass=%b captured=%h fail_vec=%0d expected 16 1 e8 0",
                     edges, pass, captured, fail_vec);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        start0   = 1'b0;
        maj_mode = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_majority();
        apply_reset();
        test_stuck();
        apply_reset();
        test_settle0();
        apply_reset();
        test_ignore_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
